// File: rtl/vector_packer_if.sv
// Stream-in / beat-out bus of the vector packer.
// master = upstream source and downstream sink; slave = the packer itself.
interface vector_packer_if #(
  parameter int bitwidth = 16,
  parameter int N        = 8
);
  localparam int CNT_W = $clog2(N) + 1;

  logic [bitwidth-1:0]   s_data;
  logic                  s_valid;
  logic                  s_last;
  logic                  s_ready;
  logic [N*bitwidth-1:0] m_data;
  logic                  m_valid;
  logic                  m_last;
  logic [CNT_W-1:0]      m_count;
  logic                  m_ready;

  modport master (
    output s_data, s_valid, s_last, m_ready,
    input  s_ready, m_data, m_valid, m_last, m_count
  );

  modport slave (
    input  s_data, s_valid, s_last, m_ready,
    output s_ready, m_data, m_valid, m_last, m_count
  );
endinterface

// File: rtl/vector_packer.sv
// Serial-to-parallel packer: gathers scalars into N-lane beats for the adder tree,
// padding short final beats with the additive identity.
module vector_packer #(
  parameter int                  bitwidth  = 16,
  parameter int                  N         = 8,
  parameter logic [bitwidth-1:0] PAD_VALUE = '0
) (
  input  logic           clk,
  input  logic           rstn,
  vector_packer_if.slave bus
);
  localparam int IDX_W = $clog2(N);
  localparam int CNT_W = $clog2(N) + 1;
  localparam logic [N-1:0][bitwidth-1:0] PAD_BEAT = {N{PAD_VALUE}};

  logic [IDX_W-1:0]              idx_q, idx_d;
  logic [N-1:0][bitwidth-1:0]    buf_q, buf_d;
  logic [N-1:0][bitwidth-1:0]    data_q, data_d;
  logic                          valid_q, valid_d;
  logic                          last_q, last_d;
  logic [CNT_W-1:0]              count_q, count_d;
  logic                          s_ready;
  logic                          accept;
  logic                          complete;

  assign s_ready  = !valid_q || bus.m_ready;
  assign accept   = bus.s_valid && s_ready;
  assign complete = accept && ((idx_q == IDX_W'(N - 1)) || bus.s_last);

  always_comb begin
    idx_d   = idx_q;
    buf_d   = buf_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    count_d = count_q;

    if (valid_q && bus.m_ready) begin
      valid_d = 1'b0;
    end

    // A completing element bypasses the buffer; lanes above it are still PAD.
    if (complete) begin
      data_d         = buf_q;
      data_d[idx_q]  = bus.s_data;
      count_d        = CNT_W'(idx_q) + CNT_W'(1);
      last_d         = bus.s_last;
      valid_d        = 1'b1;
      buf_d          = PAD_BEAT;
      idx_d          = '0;
    end else if (accept) begin
      buf_d[idx_q]   = bus.s_data;
      idx_d          = idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idx_q   <= '0;
      buf_q   <= PAD_BEAT;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      count_q <= '0;
    end else begin
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      count_q <= count_d;
    end
  end

  assign bus.s_ready = s_ready;
  assign bus.m_data  = data_q;
  assign bus.m_valid = valid_q;
  assign bus.m_last  = last_q;
  assign bus.m_count = count_q;
endmodule
